// File: rtl/ps2_arrow_keys.sv
// PS/2 keyboard receiver that tracks the four extended arrow keys.
// Frames are checked for odd parity, stop bit and inter-edge timeout.
module ps2_arrow_keys #(
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [7:0] scancode,
   output logic       scancode_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e state_q, state_d;

   logic ck_s1_q, ck_s2_q, ck_prev_q;
   logic dt_s1_q, dt_s2_q;
   logic fall;

   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          accept, reject, tmo_hit;

   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic       up_q, up_d;
   logic       down_q, down_d;
   logic       left_q, left_d;
   logic       right_q, right_d;
   logic [7:0] scan_q, scan_d;
   logic       vld_q;
   logic       err_q;

   // Synchronizers idle high so reset never fabricates an edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ck_s1_q   <= 1'b1;
         ck_s2_q   <= 1'b1;
         ck_prev_q <= 1'b1;
         dt_s1_q   <= 1'b1;
         dt_s2_q   <= 1'b1;
      end else begin
         ck_s1_q   <= ps2_clk;
         ck_s2_q   <= ck_s1_q;
         ck_prev_q <= ck_s2_q;
         dt_s1_q   <= ps2_data;
         dt_s2_q   <= dt_s1_q;
      end
   end

   assign fall = ck_prev_q & ~ck_s2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (fall && !dt_s2_q) state_d = DATA;
         end
         DATA: begin
            if (tmo_hit) state_d = IDLE;
            else if (fall && bit_cnt_q == 3'd7) state_d = PARITY;
         end
         PARITY: begin
            if (tmo_hit) state_d = IDLE;
            else if (fall) state_d = STOP;
         end
         STOP: begin
            if (tmo_hit || fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tmo_d     = '0;
      accept    = 1'b0;
      reject    = 1'b0;
      tmo_hit   = 1'b0;
      if (state_q != IDLE && !fall) begin
         tmo_hit = (tmo_q == TMO_LAST);
         tmo_d   = tmo_hit ? '0 : tmo_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (fall && !dt_s2_q) bit_cnt_d = 3'd0;
         end
         DATA: begin
            if (fall) begin
               shift_d   = {dt_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         PARITY: begin
            if (fall) par_d = dt_s2_q;
         end
         STOP: begin
            if (fall) begin
               accept = (^{shift_q, par_q}) & dt_s2_q;
               reject = ~accept;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
      end
   end

   // Prefix flags only move on accepted bytes; any bad frame drops them
   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      up_d    = up_q;
      down_d  = down_q;
      left_d  = left_q;
      right_d = right_q;
      scan_d  = scan_q;
      if (reject || tmo_hit) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (accept) begin
         scan_d = shift_q;
         if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (ext_q) begin
               unique case (1'b1)
                  shift_q == 8'h75: up_d    = ~brk_q;
                  shift_q == 8'h72: down_d  = ~brk_q;
                  shift_q == 8'h6B: left_d  = ~brk_q;
                  shift_q == 8'h74: right_d = ~brk_q;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         scan_q  <= 8'h00;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         up_q    <= up_d;
         down_q  <= down_d;
         left_q  <= left_d;
         right_q <= right_d;
         scan_q  <= scan_d;
         vld_q   <= accept;
         err_q   <= reject | tmo_hit;
      end
   end

   assign up             = up_q;
   assign down           = down_q;
   assign left           = left_q;
   assign right          = right_q;
   assign scancode       = scan_q;
   assign scancode_valid = vld_q;
   assign frame_err      = err_q;

endmodule

// File: doc/ps2_arrow_keys.md
PS2_ARROW_KEYS -- requirements
Module: ps2_arrow_keys

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200000, giving the maximum clk cycles allowed between ps2_clk falling edges inside one frame.
REQ-002 The block SHALL have port clk, input, 1, the 100 MHz system clock; it is the only clock.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port ps2_clk, input, 1, the raw keyboard clock, asynchronous to clk.
REQ-005 The block SHALL have port ps2_data, input, 1, the raw keyboard data, asynchronous to clk.
REQ-006 The block SHALL have port up, output, 1, high while the Up arrow key is held.
REQ-007 The block SHALL have port down, output, 1, high while the Down arrow key is held.
REQ-008 The block SHALL have port left, output, 1, high while the Left arrow key is held.
REQ-009 The block SHALL have port right, output, 1, high while the Right arrow key is held.
REQ-010 The block SHALL have port scancode, output, 8, the last correctly received byte.
REQ-011 The block SHALL have port scancode_valid, output, 1, a one-cycle pulse when scancode updates.
REQ-012 The block SHALL have port frame_err, output, 1, a one-cycle pulse on each rejected frame.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is a cycle with synchronized previous value 1 and current value 0.
REQ-014 The receive FSM SHALL have states IDLE, DATA, PARITY, STOP; all sampling of ps2_data SHALL occur only in falling-edge cycles.
REQ-015 IDLE: a falling edge with data=0 (start bit) SHALL go to DATA with the bit counter at 0; a falling edge with data=1 SHALL be ignored and the FSM SHALL stay in IDLE with no frame_err.
REQ-016 DATA: eight falling edges SHALL shift in data LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-017 PARITY: the sampled bit SHALL be stored; the next state SHALL be STOP.
REQ-018 STOP: a frame SHALL be accepted if the 8 data bits plus the parity bit have odd parity and the stop bit is 1; otherwise it SHALL be rejected; the FSM SHALL return to IDLE in both cases.
REQ-019 Acceptance SHALL update scancode and pulse scancode_valid for exactly one cycle, in the cycle after the stop-bit edge cycle.
REQ-020 Rejection SHALL pulse frame_err for one cycle, in the cycle after the stop-bit edge cycle, SHALL leave scancode unchanged, and SHALL clear the prefix flags.
REQ-021 In DATA, PARITY and STOP, a timeout counter SHALL count clk cycles since the last falling edge; on reaching TIMEOUT_CYCLES it SHALL abort to IDLE, pulse frame_err once, and clear the prefix flags; the counter SHALL reset on every falling edge and in IDLE.
REQ-022 The decoder SHALL keep prefix flags ext and brk, both updated only on accepted bytes.
- 0xE0 SHALL set ext.
- 0xF0 SHALL set brk.
REQ-023 Any other accepted byte SHALL clear ext and brk after use; if ext was set, it SHALL set the matching key output to NOT brk:
- 0x75 = up
- 0x72 = down
- 0x6B = left
- 0x74 = right
REQ-024 Non-extended bytes and unlisted extended codes SHALL not change any key output; repeated make codes (typematic) SHALL leave the key high.
REQ-025 Key outputs SHALL update in the same cycle scancode_valid is high; multiple keys SHALL be held simultaneously and independently.

Reset
REQ-026 While reset is low, all of the following SHALL be cleared asynchronously:
- FSM to IDLE; bit counter, timeout counter and shift register to 0; ext and brk to 0.
- scancode to 0x00; up, down, left, right, scancode_valid and frame_err to 0.
- Synchronizer flops to 1 (bus idle).
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL be received normally.

Verification
REQ-028 The bench SHALL drive ps2_clk with a 40-clk half-period and SHALL cover these scenarios:
- Byte 0x1C, parity 0, stop 1 -> scancode=0x1C, one scancode_valid pulse, key outputs unchanged.
- Sequence E0,75 -> up=1; then E0,F0,75 -> up=0; the other keys stay 0 throughout.
- E0,6B then E0,74 -> left=1 and right=1 together; then E0,F0,6B -> left=0 and right stays 1.
- Byte 0x75 sent with the wrong parity bit -> one frame_err pulse, scancode unchanged; a following E0,75 -> up=1.
- Start bit plus 3 data bits, then ps2_clk held high with TIMEOUT_CYCLES=1000 -> frame_err pulse 1000 cycles after the last edge and FSM in IDLE; the next full frame is accepted.
- Reset pulsed low after the 5th data bit while up=1 -> up=0 and scancode=0x00 immediately; a subsequent E0,72 -> down=1.
